// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM state encoding,
// digit width and the max-count digits derived from the field moduli.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_e;

  function automatic logic [DIGIT_W-1:0] max_hi(input int modulus);
    return DIGIT_W'((modulus - 1) / 10);
  endfunction

  function automatic logic [DIGIT_W-1:0] max_lo(input int modulus);
    return DIGIT_W'((modulus - 1) % 10);
  endfunction

  localparam int DEF_SEC_MOD = 60;
  localparam int DEF_MIN_MOD = 60;

  localparam logic [DIGIT_W-1:0] SEC_MAX_HI = max_hi(DEF_SEC_MOD);
  localparam logic [DIGIT_W-1:0] SEC_MAX_LO = max_lo(DEF_SEC_MOD);
  localparam logic [DIGIT_W-1:0] MIN_MAX_HI = max_hi(DEF_MIN_MOD);
  localparam logic [DIGIT_W-1:0] MIN_MAX_LO = max_lo(DEF_MIN_MOD);

endpackage

// File: rtl/bcd_field_cnt.sv
// Two-digit BCD counter counting 0..MOD-1; carry_out flags the enabled
// increment that rolls the field back to zero.
module bcd_field_cnt
  import stopwatch_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  output logic [DIGIT_W-1:0] lo,
  output logic [DIGIT_W-1:0] hi,
  output logic               carry_out
);

  localparam logic [DIGIT_W-1:0] MAX_HI = max_hi(MOD);
  localparam logic [DIGIT_W-1:0] MAX_LO = max_lo(MOD);

  logic at_max;

  assign at_max    = (hi == MAX_HI) && (lo == MAX_LO);
  assign carry_out = en & at_max;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lo <= '0;
      hi <= '0;
    end else if (en) begin
      // The max test comes first so moduli below 10 wrap before lo reaches 9
      if (at_max) begin
        lo <= '0;
        hi <= '0;
      end else if (lo == DIGIT_W'(9)) begin
        lo <= '0;
        hi <= hi + DIGIT_W'(1);
      end else begin
        lo <= lo + DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS.t stopwatch driven by a 10 Hz enable tick, with start/stop and clear
// buttons feeding an IDLE/RUN/PAUSE controller.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int MIN_MOD = 60,
  parameter int SEC_MOD = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               btn_ss,
  input  logic               btn_clr,
  output logic [DIGIT_W-1:0] d_tenth,
  output logic [DIGIT_W-1:0] d_sec_lo,
  output logic [DIGIT_W-1:0] d_sec_hi,
  output logic [DIGIT_W-1:0] d_min_lo,
  output logic [DIGIT_W-1:0] d_min_hi,
  output logic               running,
  output logic               wrap
);

  sw_state_e state;
  logic      btn_ss_q, btn_clr_q, armed;
  logic      ss_pulse, clr_pulse;
  logic      cnt_en, tenth_carry, sec_carry, min_carry;

  // armed blocks the first post-reset cycle, so a button held through reset
  // release sees history 0 but still yields no event.
  assign ss_pulse    = armed & btn_ss  & ~btn_ss_q;
  assign clr_pulse   = armed & btn_clr & ~btn_clr_q;
  assign cnt_en      = (state == RUN) & tick & ~clr_pulse;
  assign tenth_carry = cnt_en & (d_tenth == DIGIT_W'(9));

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_ss_q  <= 1'b0;
      btn_clr_q <= 1'b0;
      armed     <= 1'b0;
    end else begin
      btn_ss_q  <= btn_ss;
      btn_clr_q <= btn_clr;
      armed     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      wrap <= min_carry;
      if (clr_pulse) begin
        state   <= IDLE;
        running <= 1'b0;
      end else if (ss_pulse) begin
        case (state)
          IDLE, PAUSE: begin
            state   <= RUN;
            running <= 1'b1;
          end
          RUN: begin
            state   <= PAUSE;
            running <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_pulse) begin
      d_tenth <= '0;
    end else if (cnt_en) begin
      d_tenth <= tenth_carry ? '0 : d_tenth + DIGIT_W'(1);
    end
  end

  bcd_field_cnt #(.MOD(SEC_MOD)) u_sec (
    .clk       (clk),
    .rst       (rst),
    .en        (tenth_carry),
    .clr       (clr_pulse),
    .lo        (d_sec_lo),
    .hi        (d_sec_hi),
    .carry_out (sec_carry)
  );

  bcd_field_cnt #(.MOD(MIN_MOD)) u_min (
    .clk       (clk),
    .rst       (rst),
    .en        (sec_carry),
    .clr       (clr_pulse),
    .lo        (d_min_lo),
    .hi        (d_min_hi),
    .carry_out (min_carry)
  );

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: a 60-minute and a 10-minute instance share stimulus
// and are compared each cycle against an elapsed-tenths reference model.
module tb_stopwatch_bcd;

  logic clk = 1'b0;
  logic rst, tick, btn_ss, btn_clr;

  logic [3:0] t60, sl60, sh60, ml60, mh60, t10, sl10, sh10, ml10, mh10;
  logic       run60, wrap60, run10, wrap10;

  always #5 clk = ~clk;

  stopwatch_bcd #(.MIN_MOD(60), .SEC_MOD(60)) u60 (
    .clk(clk), .rst(rst), .tick(tick), .btn_ss(btn_ss), .btn_clr(btn_clr),
    .d_tenth(t60), .d_sec_lo(sl60), .d_sec_hi(sh60), .d_min_lo(ml60), .d_min_hi(mh60),
    .running(run60), .wrap(wrap60)
  );

  stopwatch_bcd #(.MIN_MOD(10), .SEC_MOD(60)) u10 (
    .clk(clk), .rst(rst), .tick(tick), .btn_ss(btn_ss), .btn_clr(btn_clr),
    .d_tenth(t10), .d_sec_lo(sl10), .d_sec_hi(sh10), .d_min_lo(ml10), .d_min_hi(mh10),
    .running(run10), .wrap(wrap10)
  );

  logic [19:0] dd [2];
  logic        dr [2];
  logic        dw [2];
  assign dd[0] = {mh60, ml60, sh60, sl60, t60};
  assign dd[1] = {mh10, ml10, sh10, sl10, t10};
  assign dr[0] = run60;
  assign dr[1] = run10;
  assign dw[0] = wrap60;
  assign dw[1] = wrap10;

  int n_cmp = 0;
  int n_fail = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: elapsed time as a plain count of tenths; mode 0 idle,
  // 1 running, 2 paused.
  localparam int TOT [2] = '{36000, 6000};
  int   mt [2];
  int   mmode [2];
  bit   mw [2];
  logic pss, pclr, marm;
  logic m_ss, m_clr;

  assign m_ss  = marm & btn_ss & ~pss;
  assign m_clr = marm & btn_clr & ~pclr;

  always @(posedge clk) begin
    if (rst) begin
      marm <= 1'b0;
      pss  <= 1'b0;
      pclr <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        mt[k]    <= 0;
        mmode[k] <= 0;
        mw[k]    <= 1'b0;
      end
    end else begin
      marm <= 1'b1;
      pss  <= btn_ss;
      pclr <= btn_clr;
      for (int k = 0; k < 2; k++) begin
        if (m_clr) begin
          mt[k]    <= 0;
          mmode[k] <= 0;
          mw[k]    <= 1'b0;
        end else begin
          if (mmode[k] == 1 && tick) begin
            mt[k] <= (mt[k] + 1) % TOT[k];
            mw[k] <= (mt[k] + 1 == TOT[k]);
          end else begin
            mw[k] <= 1'b0;
          end
          if (m_ss) mmode[k] <= (mmode[k] == 1) ? 2 : 1;
        end
      end
    end
  end

  function automatic logic [19:0] to_bcd(input int t);
    int m, s;
    m = t / 600;
    s = (t / 10) % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(t % 10)};
  endfunction

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk(k == 0 ? "u60 digits" : "u10 digits", 32'(dd[k]), 32'(to_bcd(mt[k])));
        chk(k == 0 ? "u60 running" : "u10 running", 32'(dr[k]), 32'(mmode[k] == 1));
        chk(k == 0 ? "u60 wrap" : "u10 wrap", 32'(dw[k]), 32'(mw[k]));
      end
    end
  end

  task automatic cyc(input bit tk, input bit ss, input bit clr);
    tick    = tk;
    btn_ss  = ss;
    btn_clr = clr;
    @(posedge clk);
    #2;
    started = 1;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b1, btn_ss, 1'b0);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; btn_ss = 1'b1; btn_clr = 1'b0;
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    rst = 1'b0;
    repeat (3) cyc(0, 1, 0);
    chk("held-through-reset digits", 32'(dd[0]), 32'h0);
    chk("held-through-reset running", 32'(run60), 32'h0);

    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("start running", 32'(run60), 32'h1);
    ticks(25);
    chk("25 ticks u60", 32'(dd[0]), 32'h00025);
    chk("25 ticks model", 32'(to_bcd(mt[0])), 32'h00025);
    chk("25 ticks u10", 32'(dd[1]), 32'h00025);

    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("pause running", 32'(run60), 32'h0);
    ticks(10);
    chk("pause holds", 32'(dd[0]), 32'h00025);

    cyc(0, 0, 1);
    chk("clear digits", 32'(dd[0]), 32'h0);
    cyc(0, 0, 0);

    cyc(0, 1, 0);
    ticks(599);
    chk("00:59.9", 32'(dd[0]), 32'h00599);
    ticks(1);
    chk("01:00.0 u60", 32'(dd[0]), 32'h01000);
    chk("01:00.0 u10", 32'(dd[1]), 32'h01000);
    chk("01:00.0 no wrap", 32'(wrap60), 32'h0);

    ticks(5399);
    chk("u10 09:59.9", 32'(dd[1]), 32'h09599);
    ticks(1);
    chk("u10 wrap digits", 32'(dd[1]), 32'h0);
    chk("u10 wrap pulse", 32'(wrap10), 32'h1);
    chk("u10 still running", 32'(run10), 32'h1);
    chk("u60 10:00.0", 32'(dd[0]), 32'h10000);
    cyc(0, 1, 0);
    chk("u10 wrap one cycle", 32'(wrap10), 32'h0);

    ticks(29999);
    chk("u60 59:59.9", 32'(dd[0]), 32'h59599);
    chk("model 59:59.9", 32'(to_bcd(mt[0])), 32'h59599);
    ticks(1);
    chk("u60 wrap digits", 32'(dd[0]), 32'h0);
    chk("u60 wrap pulse", 32'(wrap60), 32'h1);
    chk("u60 running after wrap", 32'(run60), 32'h1);
    cyc(0, 1, 0);
    chk("u60 wrap one cycle", 32'(wrap60), 32'h0);

    ticks(34);
    chk("00:03.4", 32'(dd[0]), 32'h00034);
    cyc(0, 0, 0);
    cyc(1, 1, 1);
    chk("clr+ss+tick digits", 32'(dd[0]), 32'h0);
    chk("clr+ss+tick running", 32'(run60), 32'h0);

    cyc(0, 0, 0);
    cyc(1, 1, 0);
    chk("enter tick ignored", 32'(dd[0]), 32'h0);
    chk("enter running", 32'(run60), 32'h1);
    ticks(5);
    cyc(0, 0, 0);
    cyc(1, 1, 0);
    chk("leave tick counted", 32'(dd[1]), 32'h00006);
    chk("leave running", 32'(run10), 32'h0);
    cyc(0, 0, 0);
    cyc(1, 1, 0);
    chk("re-enter tick ignored", 32'(dd[0]), 32'h00006);

    for (int i = 0; i < 4000; i++) begin
      cyc(1'($urandom_range(0, 3) != 0),
          ($urandom_range(0, 19) == 0) ? ~btn_ss : btn_ss,
          ($urandom_range(0, 99) == 0) ? ~btn_clr : btn_clr);
    end

    cyc(0, 0, 0);
    cyc(0, 1, 0);
    ticks(7);
    rst = 1'b1;
    cyc(1, 1, 1);
    rst = 1'b0;
    chk("mid-count reset digits", 32'(dd[0]), 32'h0);
    chk("mid-count reset running", 32'(run60), 32'h0);
    cyc(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd.md
Name: stopwatch_bcd

Overview:
- Consumes the 1-cycle enable tick produced by the upstream frequency divider, configured for 10 Hz (0.1 s resolution), and counts elapsed time as BCD digits MM:SS.t.
- Start/stop and clear come from debounced push-button levels; an internal FSM controls counting.
- Outputs drive the seven-segment scan stage downstream.
- Everything runs in the system clock domain; the tick is used as an enable, never as a clock.

Parameters:
- MIN_MOD, 60, minute-field modulus; legal range 2..99; the minute field counts 0..MIN_MOD-1.
- SEC_MOD, 60, second-field modulus; fixed at 60 in normal use; legal range 2..99.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- tick  in  1  1-cycle pulse, one per 0.1 s, from the divider.
- btn_ss  in  1  debounced start/stop level; acts on its rising edge.
- btn_clr  in  1  debounced clear level; acts on its rising edge.
- d_tenth  out  4  BCD tenths digit, 0..9.
- d_sec_lo  out  4  BCD seconds units.
- d_sec_hi  out  4  BCD seconds tens.
- d_min_lo  out  4  BCD minutes units.
- d_min_hi  out  4  BCD minutes tens.
- running  out  1  high while in state RUN.
- wrap  out  1  1-cycle pulse when the count rolls over from max to zero.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) sets:
  - all digits = 0, state = IDLE, running = 0, wrap = 0;
  - edge-detector history registers = 0.
- A button held high through reset release does not produce an edge.
- Edge detect: ss_pulse = btn_ss & ~btn_ss_q. clr_pulse is formed the same way. Each is 1 cycle; holding a button high produces exactly one event.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE --ss_pulse--> RUN
  - RUN --ss_pulse--> PAUSE
  - PAUSE --ss_pulse--> RUN
  - any state --clr_pulse--> IDLE, with all digits zeroed.
- Priority: clr_pulse overrides ss_pulse in the same cycle. Result: IDLE, digits 0.
- Counting:
  - Enabled when the registered state == RUN and tick == 1.
  - A tick arriving in the same cycle as the ss_pulse that leaves RUN is still counted.
  - A tick arriving in the same cycle as the ss_pulse that enters RUN is not counted.
  - A tick coincident with clr_pulse is discarded.
- Latency: a counted tick updates the digits on the next clk edge. Outputs are registered with no combinational path from inputs.
- Digit chain:
  - tenths wraps 9->0 and carries into sec_lo.
  - sec_lo wraps 9->0 and carries into sec_hi.
  - The seconds field wraps at SEC_MOD-1 (59->00) and carries into the minute field.
  - The minute field wraps at MIN_MOD-1.
- Carries ripple combinationally within one cycle, so all digits change on the same edge.
- Wrap: a tick at max (e.g. 59:59.9) gives 00:00.0 and wrap=1 for exactly one cycle. State stays RUN.
- Digit values are always valid BCD (0..9). Tens digits never exceed the modulus tens value.
- PAUSE holds all digits. IDLE holds zeros.
- running = (state == RUN), registered.
- Reset mid-count: digits return to 0 on the reset edge regardless of tick or buttons.

Decomposition:
- Package stopwatch_pkg holds:
  - the state enum (IDLE, RUN, PAUSE; 2-bit encoding);
  - the BCD digit width (4);
  - the localparams SEC_MAX_HI/LO and MIN_MAX_HI/LO, derived from the moduli.
- Sub-module bcd_field_cnt is a two-digit BCD counter with parameter MOD.
  - Inputs: en, clr, plus clk/rst.
  - Outputs: lo, hi, carry_out (combinational: en & at max).
- Instantiate bcd_field_cnt twice, for seconds and minutes. The tenths digit is a single mod-10 counter in the top level.

Test Plan:
- rst=1 for 2 cycles with btn_ss=1 held, release -> all digits 0, running=0, no start after release.
- btn_ss rise, then 25 ticks -> running=1, display 00:02.5. btn_ss low/high again -> running=0; 10 further ticks -> display stays 00:02.5.
- Preload to 00:59.9 via 599 ticks, 1 tick -> 01:00.0, all digits change on one edge, wrap=0.
- Run to 59:59.9 (35999 ticks), 1 tick -> 00:00.0, wrap=1 for 1 cycle, running stays 1.
- btn_clr and btn_ss rising in the same cycle as a tick while in RUN at 00:03.4 -> next cycle IDLE, digits 0, running=0, tick ignored.
- MIN_MOD=10: tick at 09:59.9 -> 00:00.0 with wrap=1. Tick coincident with the leaving ss_pulse -> counted. Tick coincident with the entering ss_pulse -> not counted.
